// File: rtl/intra_dc_residual_pkg.sv
// Shared definitions for the intra DC residual stage: pixel depth,
// component codes and FSM state encodings.
package intra_dc_residual_pkg;

  localparam int DEF_BIT_DEPTH = 8;

  localparam logic [1:0] COMP_Y = 2'd0;
  localparam logic [1:0] COMP_U = 2'd1;
  localparam logic [1:0] COMP_V = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LUMA  = 3'd1,
    ST_CHR_U = 3'd2,
    ST_CHR_V = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/intra_abs_diff4.sv
// Four-lane signed difference (cur - pred) plus the sum of absolute
// differences; purely combinational so other intra modes can reuse it.
module intra_abs_diff4 #(
  parameter int BIT_DEPTH = 8
) (
  input  logic [4*BIT_DEPTH-1:0]     i_cur_row,
  input  logic [4*BIT_DEPTH-1:0]     i_pred_row,
  output logic [4*(BIT_DEPTH+1)-1:0] o_diff_row,
  output logic [11:0]                o_abs_sum
);

  logic [BIT_DEPTH-1:0] w_abs [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [BIT_DEPTH:0] w_diff;
    logic [BIT_DEPTH:0] w_neg;
    assign w_diff = {1'b0, i_cur_row[gi*BIT_DEPTH +: BIT_DEPTH]}
                  - {1'b0, i_pred_row[gi*BIT_DEPTH +: BIT_DEPTH]};
    assign w_neg  = -w_diff;
    // |diff| never exceeds 2^BIT_DEPTH-1, so the sign bit can be dropped
    assign w_abs[gi] = w_diff[BIT_DEPTH] ? w_neg[BIT_DEPTH-1:0] : w_diff[BIT_DEPTH-1:0];
    assign o_diff_row[gi*(BIT_DEPTH+1) +: BIT_DEPTH+1] = w_diff;
  end

  assign o_abs_sum = 12'(w_abs[0]) + 12'(w_abs[1]) + 12'(w_abs[2]) + 12'(w_abs[3]);

endmodule

// File: rtl/intra_dc_residual.sv
// Streams one MB (Y 16 blocks, U 4, V 4) of 4-pixel beats against the DC
// predictor, emitting prediction/residual rows and running SADs.
module intra_dc_residual
  import intra_dc_residual_pkg::*;
#(
  parameter int BIT_DEPTH = DEF_BIT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [BIT_DEPTH-1:0]       i_dc_y,
  input  logic [BIT_DEPTH-1:0]       i_dc_u,
  input  logic [BIT_DEPTH-1:0]       i_dc_v,
  output logic [1:0]                 o_uv_blk,
  input  logic                       i_cur_valid,
  output logic                       o_cur_ready,
  input  logic [4*BIT_DEPTH-1:0]     i_cur_row,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [4*BIT_DEPTH-1:0]     o_pred_row,
  output logic [4*(BIT_DEPTH+1)-1:0] o_res_row,
  output logic [1:0]                 o_res_comp,
  output logic [3:0]                 o_res_blk,
  output logic [1:0]                 o_res_line,
  output logic [15:0]                o_sad_y,
  output logic [15:0]                o_sad_uv,
  output logic                       o_done
);

  state_t r_state, w_state_next;
  logic [3:0] r_blk;
  logic [1:0] r_line;
  logic       r_res_valid;
  logic [4*BIT_DEPTH-1:0]     r_pred_row;
  logic [4*(BIT_DEPTH+1)-1:0] r_res_row;
  logic [1:0]  r_res_comp;
  logic [3:0]  r_res_blk;
  logic [1:0]  r_res_line;
  logic [15:0] r_sad_y, r_sad_uv;

  logic                       w_in_data, w_hs_in, w_hs_out, w_last_beat;
  logic [BIT_DEPTH-1:0]       w_dc;
  logic [1:0]                 w_comp;
  logic [4*BIT_DEPTH-1:0]     w_pred_row;
  logic [4*(BIT_DEPTH+1)-1:0] w_diff_row;
  logic [11:0]                w_abs_sum;

  assign w_in_data   = (r_state == ST_LUMA) || (r_state == ST_CHR_U) || (r_state == ST_CHR_V);
  assign o_cur_ready = w_in_data && (!r_res_valid || i_res_ready);
  assign w_hs_in     = i_cur_valid && o_cur_ready;
  assign w_hs_out    = r_res_valid && i_res_ready;
  assign w_last_beat = (r_line == 2'd3) && (r_blk == ((r_state == ST_LUMA) ? 4'd15 : 4'd3));
  assign o_uv_blk    = (r_state == ST_CHR_U || r_state == ST_CHR_V) ? r_blk[1:0] : 2'd0;

  always_comb begin
    w_dc   = i_dc_v;
    w_comp = COMP_V;
    case (r_state)
      ST_LUMA:  begin w_dc = i_dc_y; w_comp = COMP_Y; end
      ST_CHR_U: begin w_dc = i_dc_u; w_comp = COMP_U; end
      default:  ;
    endcase
  end

  assign w_pred_row = {4{w_dc}};

  intra_abs_diff4 #(.BIT_DEPTH(BIT_DEPTH)) u_abs_diff4 (
    .i_cur_row  (i_cur_row),
    .i_pred_row (w_pred_row),
    .o_diff_row (w_diff_row),
    .o_abs_sum  (w_abs_sum)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_next = ST_LUMA;
      ST_LUMA:  if (w_hs_in && w_last_beat) w_state_next = ST_CHR_U;
      ST_CHR_U: if (w_hs_in && w_last_beat) w_state_next = ST_CHR_V;
      ST_CHR_V: if (w_hs_in && w_last_beat) w_state_next = ST_FLUSH;
      ST_FLUSH: if (w_hs_out) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_blk       <= '0;
      r_line      <= '0;
      r_res_valid <= 1'b0;
      r_pred_row  <= '0;
      r_res_row   <= '0;
      r_res_comp  <= '0;
      r_res_blk   <= '0;
      r_res_line  <= '0;
      r_sad_y     <= '0;
      r_sad_uv    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && i_start) begin
        r_blk    <= '0;
        r_line   <= '0;
        r_sad_y  <= '0;
        r_sad_uv <= '0;
      end
      if (w_hs_in) begin
        // line advances first; blk wraps to 0 at each component boundary
        r_line <= r_line + 2'd1;
        if (r_line == 2'd3) r_blk <= w_last_beat ? 4'd0 : r_blk + 4'd1;
        r_pred_row <= w_pred_row;
        r_res_row  <= w_diff_row;
        r_res_comp <= w_comp;
        r_res_blk  <= r_blk;
        r_res_line <= r_line;
        if (r_state == ST_LUMA) r_sad_y  <= r_sad_y  + 16'(w_abs_sum);
        else                    r_sad_uv <= r_sad_uv + 16'(w_abs_sum);
      end
      if (w_hs_in)       r_res_valid <= 1'b1;
      else if (w_hs_out) r_res_valid <= 1'b0;
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_pred_row  = r_pred_row;
  assign o_res_row   = r_res_row;
  assign o_res_comp  = r_res_comp;
  assign o_res_blk   = r_res_blk;
  assign o_res_line  = r_res_line;
  assign o_sad_y     = r_sad_y;
  assign o_sad_uv    = r_sad_uv;
  assign o_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_intra_dc_residual.sv
// Randomized bench for intra_dc_residual: a beat-order/arithmetic model
// predicts every output beat and the final SADs of each MB.
module tb_intra_dc_residual;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_dc_y, i_dc_u, i_dc_v;
  logic [1:0]  o_uv_blk;
  logic        i_cur_valid = 1'b0;
  logic        o_cur_ready;
  logic [31:0] i_cur_row = '0;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [31:0] o_pred_row;
  logic [35:0] o_res_row;
  logic [1:0]  o_res_comp;
  logic [3:0]  o_res_blk;
  logic [1:0]  o_res_line;
  logic [15:0] o_sad_y, o_sad_uv;
  logic        o_done;

  always #5 clk = ~clk;

  intra_dc_residual #(.BIT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_dc_y(i_dc_y), .i_dc_u(i_dc_u), .i_dc_v(i_dc_v), .o_uv_blk(o_uv_blk),
    .i_cur_valid(i_cur_valid), .o_cur_ready(o_cur_ready), .i_cur_row(i_cur_row),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_pred_row(o_pred_row), .o_res_row(o_res_row), .o_res_comp(o_res_comp),
    .o_res_blk(o_res_blk), .o_res_line(o_res_line),
    .o_sad_y(o_sad_y), .o_sad_uv(o_sad_uv), .o_done(o_done)
  );

  // DC stage emulation: chroma DC returned combinationally for uv_blk
  logic [7:0]  dc_y_v = 8'd0;
  logic [7:0]  u_tab [4];
  logic [7:0]  v_tab [4];
  logic [31:0] rows  [96];
  always_comb begin
    i_dc_y = dc_y_v;
    i_dc_u = u_tab[o_uv_blk];
    i_dc_v = v_tab[o_uv_blk];
  end

  typedef struct packed {
    logic [1:0]  comp;
    logic [3:0]  blk;
    logic [1:0]  line;
    logic [31:0] pred;
    logic [35:0] res;
  } beat_t;
  beat_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, in_k = 0, out_k = 0, dones = 0;
  int sad_y_m = 0, sad_uv_m = 0;
  int first_out_cyc = 0, last_out_cyc = 0;
  bit prev_stall = 0;
  logic [31:0] held_pred;
  logic [35:0] held_res;
  logic [7:0]  held_pos;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int comp_of(input int k);
    return (k < 64) ? 0 : (k < 80) ? 1 : 2;
  endfunction
  function automatic int pos_of(input int k);
    return (k < 64) ? k : (k < 80) ? k - 64 : k - 80;
  endfunction
  function automatic logic [7:0] dc_of(input int k);
    int b;
    b = pos_of(k) / 4;
    if (comp_of(k) == 0) return dc_y_v;
    if (comp_of(k) == 1) return u_tab[b[1:0]];
    return v_tab[b[1:0]];
  endfunction
  function automatic logic [8:0] res_of(input int c, input int d);
    int r;
    r = c - d;
    return r[8:0];
  endfunction

  // Scoreboard and protocol observer, sampled on the falling edge
  always @(negedge clk) begin
    beat_t e;
    int c, d, r;
    cyc++;
    if (rst_n) begin
      if (o_res_valid && i_res_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          $display("beat %0d comp=%0d blk=%0d line=%0d pred=%h res=%h", out_k,
                   o_res_comp, o_res_blk, o_res_line, o_pred_row, o_res_row);
          chk("res_comp", 64'(o_res_comp), 64'(e.comp));
          chk("res_blk",  64'(o_res_blk),  64'(e.blk));
          chk("res_line", 64'(o_res_line), 64'(e.line));
          chk("pred_row", 64'(o_pred_row), 64'(e.pred));
          chk("res_row",  64'(o_res_row),  64'(e.res));
        end
        out_k++;
        if (out_k == 1) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      if (i_cur_valid && o_cur_ready) begin
        if (in_k >= 96) chk("extra_input", 64'(in_k), 64'(95));
        else begin
          d = int'(dc_of(in_k));
          e.comp = 2'(comp_of(in_k));
          e.blk  = 4'(pos_of(in_k) / 4);
          e.line = 2'(pos_of(in_k) % 4);
          e.pred = {4{d[7:0]}};
          for (int i = 0; i < 4; i++) begin
            c = int'(i_cur_row[i*8 +: 8]);
            r = c - d;
            e.res[i*9 +: 9] = res_of(c, d);
            if (e.comp == 2'd0) sad_y_m += (r < 0) ? -r : r;
            else                sad_uv_m += (r < 0) ? -r : r;
          end
          if (e.comp != 2'd0) chk("uv_blk", 64'(o_uv_blk), 64'(e.blk[1:0]));
          exp_q.push_back(e);
          in_k++;
        end
      end
      if (prev_stall && o_res_valid) begin
        chk("frozen_pred", 64'(o_pred_row), 64'(held_pred));
        chk("frozen_res",  64'(o_res_row),  64'(held_res));
        chk("frozen_pos",  64'({o_res_comp, o_res_blk, o_res_line}), 64'(held_pos));
      end
      if (o_res_valid && !i_res_ready) chk("stall_cur_ready", 64'(o_cur_ready), 64'(0));
      prev_stall = o_res_valid && !i_res_ready;
      held_pred  = o_pred_row;
      held_res   = o_res_row;
      held_pos   = {o_res_comp, o_res_blk, o_res_line};
      if (o_done) begin
        dones++;
        $display("done cyc=%0d sad_y=%0d sad_uv=%0d", cyc, o_sad_y, o_sad_uv);
        chk("done_timing", 64'(cyc), 64'(last_out_cyc + 1));
        chk("done_beats",  64'(out_k), 64'(96));
        chk("sad_y",  64'(o_sad_y),  64'(sad_y_m));
        chk("sad_uv", 64'(o_sad_uv), 64'(sad_uv_m));
      end
    end else prev_stall = 0;
  end

  task automatic check_reset_state();
    chk("rst_res_valid", 64'(o_res_valid), 64'(0));
    chk("rst_cur_ready", 64'(o_cur_ready), 64'(0));
    chk("rst_done",      64'(o_done),      64'(0));
    chk("rst_sad_y",     64'(o_sad_y),     64'(0));
    chk("rst_sad_uv",    64'(o_sad_uv),    64'(0));
    chk("rst_res_row",   64'(o_res_row),   64'(0));
    chk("rst_uv_blk",    64'(o_uv_blk),    64'(0));
  endtask

  // One MB: valid/ready percentages, optional stall window, spurious start,
  // and an optional mid-MB reset after rst_at accepted beats.
  task automatic run_mb(input int vpct, input int rpct, input int stall_at, input int stall_len,
                        input int spur_at, input int rst_at);
    int k, stall_cnt, d0;
    bit spur_done;
    in_k = 0; out_k = 0; sad_y_m = 0; sad_uv_m = 0;
    exp_q.delete();
    d0 = dones;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    k = 0; stall_cnt = 0; spur_done = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0; i_cur_valid = 1'b0; i_start = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        in_k = 0; out_k = 0; sad_y_m = 0; sad_uv_m = 0;
        return;
      end
      i_cur_valid = (k < 96) && ($urandom_range(99) < vpct);
      i_cur_row   = rows[(k < 96) ? k : 95];
      if (k == stall_at && stall_cnt < stall_len) begin
        i_res_ready = 1'b0;
        stall_cnt++;
      end else i_res_ready = ($urandom_range(99) < rpct);
      i_start = (k == spur_at) && !spur_done;
      if (i_start) spur_done = 1;
      @(negedge clk);
      if (i_cur_valid && o_cur_ready) k++;
      if (o_done) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_cur_valid = 1'b0; i_res_ready = 1'b1; i_start = 1'b0;
    chk("done_count", 64'(dones - d0), 64'(1));
  endtask

  task automatic fill_test4();
    dc_y_v = 8'd255;
    u_tab[0] = 8'd10; u_tab[1] = 8'd20; u_tab[2] = 8'd30; u_tab[3] = 8'd40;
    v_tab[0] = 8'd7;  v_tab[1] = 8'd8;  v_tab[2] = 8'd9;  v_tab[3] = 8'd250;
    for (int k = 0; k < 96; k++) begin
      if (k < 64)      rows[k] = 32'h0;
      else if (k < 80) rows[k] = {4{8'd50}};
      else             rows[k] = {4{dc_of(k)}};
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin u_tab[b] = 8'd0; v_tab[b] = 8'd0; end
    for (int k = 0; k < 96; k++) rows[k] = '0;
    @(negedge clk);
    check_reset_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // literal anchors for the model arithmetic
    chk("lit_res_neg", 64'(res_of(0, 255)), 64'(9'h101));
    chk("lit_res_pos", 64'(res_of(255, 100)), 64'(9'd155));

    // flat 128 everywhere, continuous flow
    dc_y_v = 8'd128;
    for (int b = 0; b < 4; b++) begin u_tab[b] = 8'd128; v_tab[b] = 8'd128; end
    for (int k = 0; k < 96; k++) rows[k] = {4{8'd128}};
    run_mb(100, 100, -1, 0, -1, -1);
    chk("flat_consecutive", 64'(last_out_cyc - first_out_cyc), 64'(95));
    chk("flat_sad_y", 64'(o_sad_y), 64'(0));
    chk("flat_sad_uv", 64'(o_sad_uv), 64'(0));

    // luma 255 vs dc 100, chroma equal to dc
    dc_y_v = 8'd100;
    for (int b = 0; b < 4; b++) begin u_tab[b] = 8'(60 + b); v_tab[b] = 8'(200 + b); end
    for (int k = 0; k < 96; k++) rows[k] = (k < 64) ? {4{8'd255}} : {4{dc_of(k)}};
    run_mb(100, 100, -1, 0, -1, -1);
    chk("t2_sad_y", 64'(o_sad_y), 64'(39680));
    chk("t2_sad_uv", 64'(o_sad_uv), 64'(0));

    // max negative residual, chroma DC per block
    fill_test4();
    run_mb(100, 100, -1, 0, -1, -1);
    chk("t3_sad_y", 64'(o_sad_y), 64'(65280));
    chk("t3_sad_uv", 64'(o_sad_uv), 64'(1600));
    chk("t3_model_sad_y", 64'(sad_y_m), 64'(65280));

    // 5-cycle downstream stall mid-luma
    run_mb(100, 100, 20, 5, -1, -1);
    chk("t4_sad_y", 64'(o_sad_y), 64'(65280));
    chk("t4_sad_uv", 64'(o_sad_uv), 64'(1600));

    // spurious start during U, then mid-MB reset and clean restart
    run_mb(100, 100, -1, 0, 70, -1);
    chk("t5_sad_uv", 64'(o_sad_uv), 64'(1600));
    run_mb(100, 100, -1, 0, -1, 40);
    run_mb(100, 100, -1, 0, -1, -1);
    chk("t6_sad_y", 64'(o_sad_y), 64'(65280));
    chk("t6_sad_uv", 64'(o_sad_uv), 64'(1600));

    // random data and 50% gating over three MBs
    for (int m = 0; m < 3; m++) begin
      dc_y_v = 8'($urandom_range(255));
      for (int b = 0; b < 4; b++) begin
        u_tab[b] = 8'($urandom_range(255));
        v_tab[b] = 8'($urandom_range(255));
      end
      for (int k = 0; k < 96; k++) rows[k] = $urandom;
      run_mb(50, 50, -1, 0, -1, -1);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intra_dc_residual.md
Name: intra_dc_residual

Overview:
- Downstream consumer of the intra 16x16/chroma DC precompute stage.
- Once that stage's accumulators are settled, this block streams current-MB pixel rows in 4-pixel beats and produces, per beat, the DC prediction row, the signed residual row and running SADs.
- Covers one MB: luma 16 4x4 blocks, then U 4 blocks, then V 4 blocks.
- Feeds the transform/mode-decision stage through a valid/ready interface.

Parameters:
- BIT_DEPTH, 8, pixel width; residual width BIT_DEPTH+1 signed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin MB; sampled only in IDLE
- dc_y  in  BIT_DEPTH  luma DC; stable from start to done
- dc_u  in  BIT_DEPTH  U DC for the chroma block selected by uv_blk; combinational return from the DC stage
- dc_v  in  BIT_DEPTH  V DC for the block selected by uv_blk
- uv_blk  out  2  chroma 4x4 index (0 TL, 1 TR, 2 BL, 3 BR) driven to the DC stage
- cur_valid  in  1  current-pixel beat valid
- cur_ready  out  1  beat accepted when cur_valid & cur_ready
- cur_row  in  4*BIT_DEPTH  4 pixels, pixel 0 in LSBs
- res_valid  out  1  output beat valid
- res_ready  in  1  downstream accept
- pred_row  out  4*BIT_DEPTH  prediction row (DC replicated)
- res_row  out  4*(BIT_DEPTH+1)  cur - pred per pixel, two's complement
- res_comp  out  2  0 Y, 1 U, 2 V
- res_blk  out  4  4x4 index within component (0..15 Y, 0..3 U/V)
- res_line  out  2  row within 4x4
- sad_y  out  16  luma SAD accumulator
- sad_uv  out  16  U+V SAD accumulator
- done  out  1  one-cycle pulse, MB complete

Behaviour:
- Reset: FSM=IDLE; res_valid, done = 0; sad_y, sad_uv, counters, uv_blk = 0; output data registers = 0.
- FSM states: IDLE, LUMA, CHR_U, CHR_V, FLUSH, DONE.
  - IDLE -start-> LUMA; clears sad_y, sad_uv, and the blk/line counters on that edge.
  - LUMA -> CHR_U after accepting beat blk=15, line=3.
  - CHR_U -> CHR_V after blk=3, line=3.
  - CHR_V -> FLUSH after blk=3, line=3.
  - FLUSH -> DONE when the last output beat handshakes (res_valid & res_ready).
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- Beat ordering:
  - line increments first, then blk.
  - Luma has 64 beats; U and V have 16 each; 96 beats per MB.
- cur_ready = (state in LUMA/CHR_U/CHR_V) & (!res_valid | res_ready). This is a single register stage with full throughput and no bubbles under continuous valid/ready.
- On an input handshake, register the following:
  - pred_row = dc replicated ×4, with dc = dc_y, dc_u or dc_v by component.
  - res_row[i] = {0,cur[i]} - {0,dc}, 9-bit signed.
  - res_comp, res_blk and res_line take the counter values of that beat.
  - res_valid is set.
- res_valid clears on output handshake without a new input handshake. Outputs hold stable while res_valid & !res_ready.
- SAD: on each input handshake, add Σ|res_row[i]| to sad_y (luma) or sad_uv (chroma).
  - Max sad_y = 256*255 = 65280, fits 16 bits with no saturation needed.
  - Max sad_uv = 32640.
  - SADs are final and stable when done=1; they hold until the next start.
- uv_blk = blk counter[1:0] during CHR_U/CHR_V, 0 otherwise. dc_u/dc_v are sampled in the same cycle as the input handshake.
- start outside IDLE is ignored.
- cur_valid in IDLE/FLUSH/DONE is not accepted (cur_ready=0).
- Asynchronous reset mid-MB returns to the reset state and discards the in-flight beat.

Decomposition:
- Shared package/defines: BIT_DEPTH (existing enc_defines), component codes Y=0/U=1/V=2, FSM state encodings.
- One natural sub-module: intra_abs_diff4. It is combinational and computes 4 signed differences plus the sum of absolute values (12-bit). It is reusable by other intra modes.

Test Plan:
- dc_y=128, dc_u=dc_v=128, all cur pixels 128, continuous valid/ready -> 96 beats on consecutive cycles, all res_row 0, sad_y=0, sad_uv=0, done exactly one cycle after the 96th output handshake.
- dc_y=100, cur luma pixels 255 and chroma pixels = dc -> every luma res = +155, sad_y = 64*4*155 = 39680 (0x9B00), sad_uv=0.
- Luma cur=0, dc_y=255 -> res = -255 (9'h101), sad_y=65280 with no wrap; chroma dc_u per uv_blk {10,20,30,40}, cur=50 -> U res {40,30,20,10}, U contribution to sad_uv = 16*(40+30+20+10) = 1600.
- res_ready held low 5 cycles mid-luma -> cur_ready=0, outputs frozen; no beat lost or duplicated; final SADs match the no-stall run.
- start pulsed during CHR_U -> ignored, ordering unchanged; rst_n asserted at beat 40 then released + start -> clean restart from Y blk0 line0, SADs from 0.
- Random cur_valid/res_ready gating (50%) over 3 back-to-back MBs -> beat sequence (comp,blk,line) exact, SADs match a reference model, one done per MB.
